// File: rtl/wav_arb_pkg.sv
// Shared types and constants for the sample-ROM fetch arbiter.
// Used by wav_fetch_arbiter; the optional word cache is enabled with WAV_CACHE_EN.
package wav_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic [7:0] SILENCE    = 8'h80;
    localparam int         AW_DEFAULT = 25;

    // SDRAM returns a 16-bit word; the byte address LSB picks the lane.
    function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request strictly after ptr wins,
// wrapping, so the previous winner has the lowest priority.
module rr_pick #(
    parameter int NV = 4,
    parameter int IW = $clog2(NV)
) (
    input  logic [NV-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic [NV-1:0] grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NV; i++) begin
            cand = IW'((int'(ptr) + i) % NV);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/wav_fetch_arbiter.sv
// Shares the sample-ROM SDRAM port between NV voice readers and the ROM download writer.
// Define WAV_CACHE_EN to add a per-voice one-word read cache.
module wav_fetch_arbiter
    import wav_arb_pkg::*;
#(
    parameter int NV      = 4,
    parameter int AW      = AW_DEFAULT,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             pause,
    input  logic [NV-1:0]    voice_req,
    input  logic [NV*AW-1:0] voice_addr,
    output logic [NV-1:0]    voice_ack,
    output logic [7:0]       voice_data,
    input  logic             dl_active,
    input  logic             dl_wr,
    input  logic [AW-1:0]    dl_addr,
    input  logic [7:0]       dl_data,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_rd,
    output logic             mem_we,
    output logic [7:0]       mem_din,
    input  logic [15:0]      mem_dout,
    input  logic             mem_ready,
    output logic             err_timeout
);

    localparam int IW = $clog2(NV);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [NV-1:0] gnt_q, gnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [NV-1:0] ack_q, ack_d;
    logic [7:0]    data_q, data_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [AW-1:0] vaddr [NV];
    logic [NV-1:0] pick_grant;
    logic [IW-1:0] pick_idx;
    logic          pick_any;

    for (genvar g = 0; g < NV; g++) begin : g_unpack
        assign vaddr[g] = voice_addr[g*AW +: AW];
    end

    rr_pick #(.NV(NV), .IW(IW)) u_pick (
        .req   (voice_req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

`ifdef WAV_CACHE_EN
    logic [AW-2:0] tag_q  [NV];
    logic [AW-2:0] tag_d  [NV];
    logic [15:0]   word_q [NV];
    logic [15:0]   word_d [NV];
    logic [NV-1:0] cval_q, cval_d;
    logic          hit;

    assign hit = cval_q[pick_idx] && (tag_q[pick_idx] == vaddr[pick_idx][AW-1:1]);
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        ack_d   = '0;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef WAV_CACHE_EN
        tag_d   = tag_q;
        word_d  = word_q;
        cval_d  = cval_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any && !pause && !dl_active) begin
                    ptr_d  = pick_idx;
                    gnt_d  = pick_grant;
                    addr_d = vaddr[pick_idx];
                    cnt_d  = '0;
`ifdef WAV_CACHE_EN
                    if (hit) begin
                        data_d  = byte_sel(word_q[pick_idx], vaddr[pick_idx][0]);
                        ack_d   = pick_grant;
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: state_d = dl_active ? IDLE : WAIT;
            WAIT: begin
                // A download takes the port mid-read; the voice keeps req and is re-picked later.
                if (dl_active) begin
                    state_d = IDLE;
                end else if (mem_ready) begin
                    data_d  = byte_sel(mem_dout, addr_q[0]);
                    ack_d   = gnt_q;
                    state_d = DONE;
`ifdef WAV_CACHE_EN
                    tag_d[ptr_q]  = addr_q[AW-1:1];
                    word_d[ptr_q] = mem_dout;
                    cval_d[ptr_q] = 1'b1;
`endif
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    data_d  = SILENCE;
                    ack_d   = gnt_q;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef WAV_CACHE_EN
        if (dl_active) cval_d = '0;
`endif
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NV - 1);
            gnt_q   <= '0;
            addr_q  <= '0;
            ack_q   <= '0;
            data_q  <= SILENCE;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef WAV_CACHE_EN
    always_ff @(posedge clk_sys) begin
        if (reset) cval_q <= '0;
        else       cval_q <= cval_d;
        tag_q  <= tag_d;
        word_q <= word_d;
    end
`endif

    assign voice_ack   = ack_q;
    assign voice_data  = data_q;
    assign err_timeout = err_q;
    assign mem_rd      = (state_q == ISSUE) && !dl_active;
    assign mem_we      = dl_active && dl_wr;
    assign mem_addr    = dl_active ? dl_addr : {addr_q[AW-1:1], 1'b0};
    assign mem_din     = dl_active ? dl_data : 8'h00;

endmodule

// File: tb/tb_wav_fetch_arbiter.sv
// Bench for wav_fetch_arbiter: random voice traffic against a round-robin / latency
// reference model, plus directed download-abort, timeout, pause and cache scenarios.
module tb_wav_fetch_arbiter;

  localparam int NV      = 4;
  localparam int AW      = 25;
  localparam int TIMEOUT = 64;

  logic             clk_sys;
  logic             reset;
  logic             pause;
  logic [NV-1:0]    voice_req;
  logic [NV*AW-1:0] voice_addr;
  logic [NV-1:0]    voice_ack;
  logic [7:0]       voice_data;
  logic             dl_active;
  logic             dl_wr;
  logic [AW-1:0]    dl_addr;
  logic [7:0]       dl_data;
  logic [AW-1:0]    mem_addr;
  logic             mem_rd;
  logic             mem_we;
  logic [7:0]       mem_din;
  logic [15:0]      mem_dout;
  logic             mem_ready;
  logic             err_timeout;

  logic [AW-1:0] va [NV];

  for (genvar g = 0; g < NV; g++) begin : g_pack
    assign voice_addr[g*AW +: AW] = va[g];
  end

  wav_fetch_arbiter #(.NV(NV), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .pause       (pause),
    .voice_req   (voice_req),
    .voice_addr  (voice_addr),
    .voice_ack   (voice_ack),
    .voice_data  (voice_data),
    .dl_active   (dl_active),
    .dl_wr       (dl_wr),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_we      (mem_we),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .mem_ready   (mem_ready),
    .err_timeout (err_timeout)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int          fix_lat;
  logic        hang;
  logic        fix_word_en;
  logic [15:0] fix_word;
  logic        pend;
  logic [AW-1:0] pend_addr;
  int          lat_left;

  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] x;
    x = 32'(a >> 1) * 32'h9E3779B1;
    return x[31:16] ^ x[15:0];
  endfunction

  task automatic mem_step();
    mem_ready = 1'b0;
    if (dl_active) pend = 1'b0;
    if (pend) begin
      if (lat_left == 0) begin
        mem_ready = 1'b1;
        mem_dout  = fix_word_en ? fix_word : mem_word(pend_addr);
        pend      = 1'b0;
      end else begin
        lat_left--;
      end
    end
    if (mem_rd && !hang) begin
      pend      = 1'b1;
      pend_addr = mem_addr;
      lat_left  = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 5));
    end
  endtask

  // ---------------- voice drivers ----------------
  logic auto_on;
  logic pause_rand;
  int   gap_max;
  int   gap [NV];

  task automatic drive_step();
    for (int v = 0; v < NV; v++) begin
      if (voice_ack[v]) begin
        voice_req[v] = 1'b0;
        gap[v] = $urandom_range(0, gap_max);
      end else if (auto_on && !voice_req[v]) begin
        if (gap[v] == 0) begin
          va[v] = AW'($urandom);
          voice_req[v] = 1'b1;
        end else begin
          gap[v]--;
        end
      end
    end
    if (auto_on && pause_rand) pause = ($urandom_range(0, 7) == 0);
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [NV+7:0] exp_q[$];
  logic          model_on;
  logic [NV-1:0] req_edge;
  logic          prev_rd;
  logic          busy;
  logic          exp_err;
  logic [7:0]    last_data;
  int            last_win;
  int            cur_voice;
  logic [AW-1:0] cur_addr;
  int            issue_cyc;
  int            cyc;

  function automatic int rr_next(input logic [NV-1:0] r, input int last);
    for (int i = 1; i <= NV; i++)
      if (r[(last + i) % NV]) return (last + i) % NV;
    return -1;
  endfunction

  task automatic model_step();
    logic [NV+7:0] e;
    logic [NV-1:0] oh;
    int w;
    cyc++;
    if (reset) begin
      exp_q.delete();
      busy = 1'b0; exp_err = 1'b0; prev_rd = 1'b0;
      last_win = NV - 1; last_data = 8'h80;
      return;
    end
    chk("err_timeout", err_timeout, exp_err);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ack_vec", voice_ack, e[NV+7:8]);
      chk("ack_data", voice_data, e[7:0]);
      last_data = e[7:0];
    end else begin
      chk("no_ack", voice_ack, 0);
      chk("data_hold", voice_data, last_data);
    end
    chk("mem_we", mem_we, dl_active & dl_wr);
    if (mem_rd) begin
      chk("rd_pulse", prev_rd, 0);
      w = rr_next(req_edge, last_win);
      chk("rd_has_req", 32'(w >= 0), 1);
      if (w >= 0) begin
        chk("rd_addr", mem_addr, {va[w][AW-1:1], 1'b0});
        last_win = w; cur_voice = w; cur_addr = va[w];
        busy = 1'b1; issue_cyc = cyc;
      end
    end
    oh = NV'(1) << cur_voice;
    if (busy && mem_ready) begin
      exp_q.push_back({oh, cur_addr[0] ? mem_dout[15:8] : mem_dout[7:0]});
      busy = 1'b0;
    end else if (busy && hang && cyc == issue_cyc + TIMEOUT) begin
      exp_q.push_back({oh, 8'h80});
      busy = 1'b0;
      exp_err = 1'b1;
    end
    if (dl_active) busy = 1'b0;
    prev_rd = mem_rd;
  endtask

  task automatic step();
    @(posedge clk_sys);
    req_edge = voice_req;
    #1;
    mem_step();
    drive_step();
    @(negedge clk_sys);
    if (model_on) model_step();
  endtask

  task automatic wait_rd(input string tag, input int max);
    int i;
    for (i = 0; i < max && !mem_rd; i++) step();
    chk(tag, mem_rd, 1);
  endtask

  task automatic wait_ack(input string tag, input int v, input int max);
    int i;
    for (i = 0; i < max && !voice_ack[v]; i++) step();
    chk(tag, voice_ack, NV'(1) << v);
  endtask

  task automatic drain();
    int i;
    auto_on = 1'b0; pause_rand = 1'b0; pause = 1'b0;
    for (i = 0; i < 300 && voice_req != '0; i++) step();
    chk("drain", voice_req, 0);
    repeat (3) step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_rd;
    logic [15:0] wv;
    reset = 1'b1; pause = 1'b0; voice_req = '0;
    dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    mem_dout = '0; mem_ready = 1'b0;
    fix_lat = -1; hang = 1'b0; fix_word_en = 1'b0; fix_word = '0;
    pend = 1'b0; pend_addr = '0; lat_left = 0;
    auto_on = 1'b0; pause_rand = 1'b0; gap_max = 0;
    model_on = 1'b1; req_edge = '0; prev_rd = 1'b0; busy = 1'b0; exp_err = 1'b0;
    last_data = 8'h80; last_win = NV - 1; cur_voice = 0; cur_addr = '0; issue_cyc = 0; cyc = 0;
    for (int v = 0; v < NV; v++) begin va[v] = '0; gap[v] = 0; end

    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_ack", voice_ack, 0);
    chk("rst_data", voice_data, 8'h80);
    chk("rst_rd", mem_rd, 0);
    chk("rst_err", err_timeout, 0);

    // Voice 0 byte read, high lane.
    fix_lat = 4; fix_word_en = 1'b1; fix_word = 16'hBEEF;
    va[0] = 25'h000101; voice_req[0] = 1'b1;
    wait_rd("t1_rd", 10);
    chk("t1_mem_addr", mem_addr, 25'h000100);
    wait_ack("t1_ack", 0, 20);
    chk("t1_data", voice_data, 8'hBE);
    fix_lat = -1; fix_word_en = 1'b0;
    repeat (3) step();

    // All voices requesting back to back.
    gap_max = 0; auto_on = 1'b1;
    repeat (80) step();
    drain();

    // Random traffic with random pause.
    gap_max = 3; auto_on = 1'b1; pause_rand = 1'b1;
    repeat (2000) step();
    drain();

    // Download takes the port during a read of voice 2.
    hang = 1'b1;
    va[2] = AW'($urandom); voice_req[2] = 1'b1;
    wait_rd("t3_rd", 10);
    repeat (3) step();
    dl_active = 1'b1; dl_wr = 1'b1; dl_addr = 25'h10; dl_data = 8'h5A;
    #1;
    chk("t3_we", mem_we, 1);
    chk("t3_addr", mem_addr, 25'h10);
    chk("t3_din", mem_din, 8'h5A);
    chk("t3_rd", mem_rd, 0);
    step();
    dl_wr = 1'b0;
    repeat (4) step();
    chk("t3_no_ack", voice_ack, 0);
    hang = 1'b0; dl_active = 1'b0;
    wait_ack("t3_reissue_ack", 2, 30);
    repeat (3) step();

    // Read that never completes.
    hang = 1'b1;
    va[3] = AW'($urandom); voice_req[3] = 1'b1;
    wait_ack("t4_ack", 3, TIMEOUT + 20);
    chk("t4_data", voice_data, 8'h80);
    hang = 1'b0;
    repeat (5) step();
    chk("t4_err_sticky", err_timeout, 1);

    // Pause holds off new grants but not an in-flight read.
    pause = 1'b1;
    va[1] = AW'($urandom); voice_req[1] = 1'b1;
    n_rd = 0;
    repeat (12) begin step(); if (mem_rd) n_rd++; end
    chk("t5_pause_rd", n_rd, 0);
    pause = 1'b0; fix_lat = 6;
    wait_rd("t5_rd", 5);
    step();
    pause = 1'b1;
    wait_ack("t5_ack", 1, 20);
    pause = 1'b0; fix_lat = -1;
    repeat (3) step();

    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("rst2_err", err_timeout, 0);
    chk("rst2_data", voice_data, 8'h80);

`ifdef WAV_CACHE_EN
    // Second read of the same word is served from the cache.
    model_on = 1'b0;
    va[1] = 25'h20; voice_req[1] = 1'b1; n_rd = 0;
    for (int i = 0; i < 30 && !voice_ack[1]; i++) begin step(); if (mem_rd) n_rd++; end
    chk("c_first_ack", voice_ack[1], 1);
    step();
    va[1] = 25'h21; voice_req[1] = 1'b1;
    begin
      int k;
      k = 0;
      for (int i = 0; i < 10 && !voice_ack[1]; i++) begin step(); k++; if (mem_rd) n_rd++; end
      chk("c_second_ack", voice_ack[1], 1);
      chk("c_latency", 32'(k <= 3), 1);
    end
    wv = mem_word(25'h20);
    chk("c_rd_count", n_rd, 1);
    chk("c_data", voice_data, wv[15:8]);
    repeat (3) step();
`else
    wv = '0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
